// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, memory enable codes and FSM states for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WE_READ = 2'b00;
    localparam logic [1:0] WE_WORD = 2'b01;
    localparam logic [1:0] WE_BYTE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LO,
        ST_RD_HI,
        ST_CAPTURE,
        ST_WR_LO,
        ST_WR_HI,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane load extraction and store merge over a two-word window
import lsu_pkg::*;

module lsu_lane_align (
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] window_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [63:0] store_window_o
);

    logic [31:0] shifted;
    logic [7:0]  lane_mask;
    logic [63:0] bit_mask;
    logic [63:0] data_pos;

    // Shift the {hi,lo} window down to the access offset, extend loads, and merge store bytes in place
    always_comb begin
        shifted = 32'(window_i >> {offset_i, 3'b000});
        case (funct3_i)
            F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data_o = {24'h0, shifted[7:0]};
            F3_HU:   load_data_o = {16'h0, shifted[15:0]};
            default: load_data_o = shifted;
        endcase

        case (funct3_i[1:0])
            2'b00:   lane_mask = 8'h01 << offset_i;
            2'b01:   lane_mask = 8'h03 << offset_i;
            default: lane_mask = 8'h0F << offset_i;
        endcase

        for (int i = 0; i < 8; i++) begin
            bit_mask[i*8 +: 8] = {8{lane_mask[i]}};
        end
        data_pos       = {32'h0, store_data_i} << {offset_i, 3'b000};
        store_window_o = (window_i & ~bit_mask) | (data_pos & bit_mask);
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV32 load/store sequencer with read-modify-write and word-split handling
import lsu_pkg::*;

module lsu_mem_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        mem_we,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q;
    logic              we_q;
    logic              split_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] w0_q;
    logic [ADDR_W-1:0] w1;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q, hi_q, lo_d, hi_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [1:0]        mem_we_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [31:0]       resp_rdata_q;
    logic [ADDR_W-1:0] req_w0;
    logic              req_illegal;
    logic              req_split;
    logic              req_sw_aligned;
    logic [31:0]       load_data;
    logic [63:0]       store_window;
    logic              unused_addr_hi;

    assign req_w0         = req_addr[ADDR_W+1:2];
    assign w1             = w0_q + ADDR_W'(1);
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign req_ready  = (state_q == ST_IDLE) && !RST;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = RST ? WE_READ : mem_we_q;

    // Decode the incoming request: legality, word-crossing, and the no-read aligned word store
    always_comb begin
        if (req_we) begin
            req_illegal = req_funct3[2];
        end else begin
            req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        case (req_funct3[1:0])
            2'b00:   req_split = 1'b0;
            2'b01:   req_split = (req_addr[1:0] == 2'b11);
            default: req_split = (req_addr[1:0] != 2'b00);
        endcase
        req_sw_aligned = req_we && (req_funct3 == F3_W) && (req_addr[1:0] == 2'b00);
    end

    // Next buffer contents: read data lands one cycle after its address, low word first
    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (state_q == ST_RD_HI) begin
            lo_d = mem_rdata;
        end else if (state_q == ST_CAPTURE) begin
            if (split_q) begin
                hi_d = mem_rdata;
            end else begin
                lo_d = mem_rdata;
            end
        end
    end

    // Aligner sees the buffers as they will be after this edge, so CAPTURE can hand off directly
    lsu_lane_align u_align (
        .offset_i       (off_q),
        .funct3_i       (f3_q),
        .window_i       ({hi_d, lo_d}),
        .store_data_i   (wdata_q),
        .load_data_o    (load_data),
        .store_window_o (store_window)
    );

    // Sequencer: outputs are registered on entry to the state that uses them
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            split_q      <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            w0_q         <= '0;
            wdata_q      <= 32'h0;
            lo_q         <= 32'h0;
            hi_q         <= 32'h0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_we_q     <= WE_READ;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            mem_we_q     <= WE_READ;
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        w0_q    <= req_w0;
                        wdata_q <= req_wdata;
                        split_q <= req_split;
                        if (req_illegal) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else if (req_sw_aligned) begin
                            state_q     <= ST_WR_LO;
                            mem_addr_q  <= req_w0;
                            mem_wdata_q <= req_wdata;
                            mem_we_q    <= WE_WORD;
                        end else begin
                            state_q    <= ST_RD_LO;
                            mem_addr_q <= req_w0;
                        end
                    end
                end
                ST_RD_LO: begin
                    if (split_q) begin
                        state_q    <= ST_RD_HI;
                        mem_addr_q <= w1;
                    end else begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_RD_HI: state_q <= ST_CAPTURE;
                ST_CAPTURE: begin
                    if (we_q) begin
                        state_q     <= ST_WR_LO;
                        mem_addr_q  <= w0_q;
                        mem_wdata_q <= store_window[31:0];
                        mem_we_q    <= WE_WORD;
                    end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data;
                    end
                end
                ST_WR_LO: begin
                    if (split_q) begin
                        state_q     <= ST_WR_HI;
                        mem_addr_q  <= w1;
                        mem_wdata_q <= store_window[63:32];
                        mem_we_q    <= WE_WORD;
                    end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'h0;
                    end
                end
                ST_WR_HI: begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl against a byte-addressed reference model
module tb_lsu_mem_ctrl;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_we;
    logic [31:0] mem_rdata;

    lsu_mem_ctrl #(.ADDR_W(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        we;
        logic        split;
        logic        chk_rd;
        logic [15:0] w0;
        logic [15:0] w1;
        int          lat;
        int          acc;
        int          nwr;
    } exp_t;

    exp_t        exp_q[$];
    logic [17:0] wr_log[$];
    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic        mem_init;
    logic        mem_pre;
    logic [15:0] rd_a0;
    logic [15:0] rd_a1;
    logic [31:0] last_rdata;
    int          cyc;
    int          n_checks;
    int          n_fail;

    logic [2:0]  d_f3   [7] = '{3'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd5, 3'd2};
    logic [31:0] d_addr [7] = '{32'h41, 32'h42, 32'h42, 32'h40, 32'h42, 32'h42, 32'h43};
    logic [31:0] d_exp  [7] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000FF, 32'h80FF7F01,
                                32'hFFFF80FF, 32'h000080FF, 32'h34567880};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [15:0] word_of(logic [31:0] a);
        return a[17:2];
    endfunction

    function automatic logic [7:0] ref_byte(logic [31:0] a);
        logic [31:0] w;
        w = ref_mem[word_of(a)];
        return w[8*int'(a[1:0]) +: 8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural data memory: one-cycle registered read, word writes on mem_we=01
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
        end else if (mem_pre) begin
            mem[16'h10] <= 32'h80FF7F01;
            mem[16'h11] <= 32'h12345678;
        end else if (mem_we == 2'b01) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // Reference model: byte-granular view of the access, latency by request class
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output exp_t e);
        int          sz;
        logic [31:0] v;
        logic [31:0] b;
        sz       = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        e.we     = we;
        e.acc    = 0;
        e.err    = we ? f3[2] : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        e.w0     = word_of(a);
        e.w1     = word_of(a + 32'(sz - 1));
        e.split  = !e.err && (e.w0 != e.w1);
        e.rdata  = 32'h0;
        e.nwr    = 0;
        e.chk_rd = 1'b0;
        if (e.err) begin
            e.lat = 1;
        end else if (!we) begin
            v = 32'h0;
            for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_byte(a + 32'(k));
            if (sz == 1) v = f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            if (sz == 2) v = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            e.rdata  = v;
            e.lat    = e.split ? 4 : 3;
            e.chk_rd = 1'b1;
        end else begin
            for (int k = 0; k < sz; k++) begin
                b = a + 32'(k);
                ref_mem[word_of(b)][8*int'(b[1:0]) +: 8] = wd[8*k +: 8];
            end
            e.nwr = e.split ? 2 : 1;
            if (f3 == 3'd2 && a[1:0] == 2'b00) begin
                e.lat = 2;
            end else begin
                e.lat    = e.split ? 6 : 4;
                e.chk_rd = 1'b1;
            end
        end
    endtask

    // Monitor: track memory traffic of the outstanding request and score each response
    always @(negedge CLK) begin
        exp_t cur;
        if (!RST) begin
            if (exp_q.size() != 0) begin
                cur = exp_q[0];
                if (cyc == cur.acc + 1) rd_a0 = mem_addr;
                if (cyc == cur.acc + 2) rd_a1 = mem_addr;
                if (mem_we != 2'b00 && cyc > cur.acc) wr_log.push_back({mem_we, mem_addr});
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid), 32'h0);
                end else begin
                    cur = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, cur.rdata);
                    check("resp_err", 32'(resp_err), 32'(cur.err));
                    check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    check("write_count", 32'(wr_log.size()), 32'(cur.nwr));
                    for (int i = 0; i < wr_log.size() && i < cur.nwr; i++) begin
                        check("write_slot", 32'(wr_log[i]),
                              32'({2'b01, (i == 0) ? cur.w0 : cur.w1}));
                    end
                    if (cur.chk_rd) begin
                        check("read_addr_lo", 32'(rd_a0), 32'(cur.w0));
                        if (cur.split) check("read_addr_hi", 32'(rd_a1), 32'(cur.w1));
                    end
                    if (cur.we && !cur.err) begin
                        check("mem_word_lo", mem[cur.w0], ref_mem[cur.w0]);
                        if (cur.split) check("mem_word_hi", mem[cur.w1], ref_mem[cur.w1]);
                    end
                    last_rdata = resp_rdata;
                    wr_log.delete();
                end
            end
        end
    end

    // Issue one request at a negedge and wait (bounded) for the scoreboard to drain
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        exp_t e;
        int   n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'h1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        model(we, f3, a, wd, e);
        e.acc = cyc;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("resp_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
            wr_log.delete();
        end
    endtask

    task automatic preload();
        mem_pre = 1'b1;
        @(negedge CLK);
        mem_pre = 1'b0;
        ref_mem[16'h10] = 32'h80FF7F01;
        ref_mem[16'h11] = 32'h12345678;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;
        cyc        = 0;
        n_checks   = 0;
        n_fail     = 0;
        RST        = 1'b1;
        mem_init   = 1'b1;
        mem_pre    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);

        @(posedge CLK);
        #1 mem_init = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_rst", 32'(req_ready), 32'h1);

        preload();
        for (int i = 0; i < 7; i++) begin
            do_req(1'b0, d_f3[i], d_addr[i], 32'h0);
            check($sformatf("load_const_%0d", i), last_rdata, d_exp[i]);
        end
        do_req(1'b0, 3'b010, 32'h0003FFFF, 32'h0);
        do_req(1'b0, 3'b011, 32'h40, 32'h0);

        preload();
        do_req(1'b1, 3'b000, 32'h41, 32'h000000AB);
        check("sb_word10", mem[16'h10], 32'h80FFAB01);
        preload();
        do_req(1'b1, 3'b010, 32'h44, 32'hDEADBEEF);
        check("sw_word11", mem[16'h11], 32'hDEADBEEF);
        preload();
        do_req(1'b1, 3'b001, 32'h43, 32'h0000CAFE);
        check("sh_word10", mem[16'h10], 32'hFEFF7F01);
        check("sh_word11", mem[16'h11], 32'h123456CA);

        preload();
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h44;
        req_wdata  = 32'hDEADBEEF;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        RST       = 1'b1;
        @(negedge CLK);
        check("rst_mid_write_we", 32'(mem_we), 32'h0);
        check("rst_mid_write_resp", 32'(resp_valid), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_mid_rst", 32'(req_ready), 32'h1);
        check("rst_mid_write_mem", mem[16'h11], 32'h12345678);
        check("rst_mid_write_noresp", 32'(resp_valid), 32'h0);

        for (int t = 0; t < 300; t++) begin
            we = 1'($urandom);
            r  = $urandom_range(0, 9);
            if (r < 6)      a = 32'h40 + 32'($urandom_range(0, 31));
            else if (r < 8) a = $urandom;
            else            a = ($urandom & 32'hFFFC0000) | (32'h0003FFF8 + 32'($urandom_range(0, 7)));
            if ($urandom_range(0, 9) == 0) begin
                f3 = we ? 3'(4 + $urandom_range(0, 3)) : ((r % 3 == 0) ? 3'd3 : (r % 3 == 1) ? 3'd6 : 3'd7);
            end else if (we) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                r  = $urandom_range(0, 4);
                f3 = (r < 3) ? 3'(r) : 3'(r + 1);
            end
            do_req(we, f3, a, $urandom);
            r = $urandom_range(0, 2);
            for (int g = 0; g < r; g++) @(negedge CLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
